// File: rtl/two_bit_lower.sv
// rtl/two_bit_lower.sv - loadable down-counter with zero flag and registered done pulse
// Decrement is out + all-ones; WRAP selects saturate-at-zero or wrap-to-max.

module two_bit_lower #(
  parameter int WIDTH = 2,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             done
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] next_out;
  logic             at_one;
  logic             next_done;

  // Adding all-ones is a decrement modulo 2^WIDTH; 0 naturally becomes max.
  assign dec_val  = out + ALL_ONES;
  assign zero     = (out == '0);
  assign at_one   = (out == ONE);
  assign step_val = (zero && !WRAP) ? out : dec_val;
  assign next_out = load ? load_val : (en ? step_val : out);

  // Only a genuine 1->0 step raises done; loads and holds at zero never do.
  assign next_done = !load && en && at_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      done <= 1'b0;
    end else begin
      out  <= next_out;
      done <= next_done;
    end
  end

endmodule

// File: doc/two_bit_lower.md
Name: two_bit_lower

Overview:
- Loadable down-counter; the count-down counterpart of the enable-driven up-counter.
- Serves as a countdown timer or remaining-count tracker in the datapath. A controller loads a start value, steps it with en, and watches zero and done.
- Built from the same primitive set as the up-counter: adder with all-ones operand (decrement), 2:1 muxes, and a register with async reset.
- Width is parameterised. Default 2 bits matches the existing up-counter.

Parameters:
- WIDTH, 2, counter width in bits; legal range 1..16.
- WRAP, 0, behaviour at zero: 0 = hold at 0 (saturate); 1 = wrap from 0 to 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; decrement on the rising edge while high.
- load  input  1  synchronous load strobe; takes priority over en.
- load_val  input  WIDTH  value captured when load=1.
- out  output  WIDTH  current count (register output).
- zero  output  1  combinational flag, high when out==0.
- done  output  1  registered one-cycle pulse, high on the cycle after the count steps from 1 to 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: asserting rst immediately forces out=0 and done=0, regardless of clk; zero=1 as a consequence.
  - Reset has priority over load and en.
  - On the first rising edge after rst deasserts, normal operation resumes with no dead cycle.
- Next-state priority at each rising edge, rst low:
  1. load=1: out <= load_val, whether en is 0 or 1; done <= 0.
  2. load=0, en=1, out!=0: out <= out-1 (modulo 2^WIDTH via the adder; carry-out discarded).
  3. load=0, en=1, out==0, WRAP=0: out holds at 0.
  4. load=0, en=1, out==0, WRAP=1: out <= 2^WIDTH-1.
  5. load=0, en=0: out holds.
- Latency: one cycle from load/en sampled high to out updated.
- zero: purely combinational from the out register, so it follows out in the same cycle. It is never registered separately.
- done:
  - done <= 1 exactly when load=0, en=1 and out==1 at the edge; otherwise done <= 0.
  - So done is high for exactly one cycle, coincident with the first cycle in which out==0 after a decrement.
  - Loading 0 does not raise done.
  - With WRAP=0, holding en high at 0 does not re-raise done.
  - With WRAP=1, every 1->0 step raises done; the 0->max wrap does not.
- Load mid-countdown: the new value replaces the count immediately; any pending countdown is abandoned with no done pulse.
- Simultaneous load and en: load wins; en is ignored that cycle.
- Reset mid-countdown: out goes to 0 asynchronously and done is cleared (no pulse). zero rises immediately.
- No X propagation: all state bits are reset. load_val is don't-care when load=0.

Test Plan:
- Reset: pulse rst between clock edges with out=2 -> out=0, zero=1, done=0 before the next edge; first post-reset edge with load=1, load_val=3 -> out=3.
- Countdown with WIDTH=2, WRAP=0: load 3, then en=1 for 5 cycles -> out sequence 3,2,1,0,0,0. done=1 only in the cycle out first reads 0. zero=1 from that cycle on.
- Wrap with WIDTH=2, WRAP=1: load 1, en=1 for 4 cycles -> out 1,0,3,2,1. done high only in the cycle showing the first 0.
- Load priority: while counting at out=2, drive load=1, en=1, load_val=3 -> out=3 next cycle and done stays 0. Load 0 -> out=0, zero=1, done=0.
- Enable gating: at out=2, toggle en 1,0,0,1 -> out 1,1,1,0. done pulses once, only on the final step.
- Async reset mid-count with WIDTH=4: load 9, decrement to 5, assert rst mid-cycle -> out=0 immediately with no done pulse; release, load 1, en 1 cycle -> out=0 and done pulses once.
